// File: rtl/seg_skid_reg.sv
// seg_skid_reg: one-entry-plus-skid pipeline register stage.
// A main register feeds out_data; a skid register absorbs one extra payload
// so that in_ready and out_valid come straight from flops, with no
// combinational path from in_valid or out_ready.
// Optional feature: define SEG_SKID_STATS_EN to add a saturating 16-bit
// counter of output stall cycles (out_valid=1, out_ready=0) on stall_cnt.
module seg_skid_reg #(
  parameter int REG_SIZE = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [REG_SIZE-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [REG_SIZE-1:0] out_data,
  output logic [1:0]          occupancy
`ifdef SEG_SKID_STATS_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [REG_SIZE-1:0] main_q, main_d;
  logic [REG_SIZE-1:0] skid_q, skid_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic [1:0]          occ_q, occ_d;
  logic                in_xfer;
  logic                out_xfer;

  // Handshakes are qualified only by registered ready/valid flags.
  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid_q & out_ready;

  // Next state and payload movement; flush empties the stage but keeps data.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_d  = in_data;
            state_d = ST_BUSY;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_BUSY: begin
          if (in_xfer && out_xfer) begin
            main_d  = in_data;
            state_d = ST_BUSY;
          end else if (in_xfer) begin
            skid_d  = in_data;
            state_d = ST_FULL;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_BUSY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so in_valid cannot cause a transfer.
          if (out_xfer) begin
            main_d  = skid_q;
            state_d = ST_BUSY;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Handshake flags and occupancy are decoded from the next state so they
  // can be registered alongside it.
  always_comb begin
    out_valid_d = 1'b0;
    in_ready_d  = 1'b1;
    occ_d       = 2'd0;
    case (state_d)
      ST_EMPTY: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        occ_d       = 2'd0;
      end
      ST_BUSY: begin
        out_valid_d = 1'b1;
        in_ready_d  = 1'b1;
        occ_d       = 2'd1;
      end
      ST_FULL: begin
        out_valid_d = 1'b1;
        in_ready_d  = 1'b0;
        occ_d       = 2'd2;
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        occ_d       = 2'd0;
      end
    endcase
  end

  // State, payload and output flag registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      occ_q       <= occ_d;
    end
  end

  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign out_data  = main_q;
  assign occupancy = occ_q;

`ifdef SEG_SKID_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Count cycles where a valid head waits on the consumer, saturating.
  always_comb begin
    if (out_valid_q && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register; cleared only by reset, never by flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_seg_skid_reg.sv
// Self-checking bench for seg_skid_reg: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_seg_skid_reg;

  localparam int W = 64;

  logic         clk;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;
`ifdef SEG_SKID_STATS_EN
  logic [15:0]  stall_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: FIFO of at most two payloads plus the last head shown.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_last;
  logic [15:0]  m_stall;

  seg_skid_reg #(.REG_SIZE(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef SEG_SKID_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    logic pop, push;
    if (reset) begin
      mq.delete();
      m_last  = '0;
      m_stall = 16'd0;
    end else begin
      if (mq.size() > 0 && !out_ready && m_stall != 16'hFFFF) m_stall++;
      if (mq.size() > 0) m_last = mq[0];
      if (flush) begin
        mq.delete();
      end else begin
        pop  = (mq.size() > 0) && out_ready;
        push = in_valid && (mq.size() < 2);
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(in_data);
      end
    end
  endtask

  task automatic check_all();
    chk("out_valid", {63'd0, out_valid}, {63'd0, mq.size() > 0});
    chk("in_ready",  {63'd0, in_ready},  {63'd0, mq.size() < 2});
    chk("occupancy", {62'd0, occupancy}, 64'(mq.size()));
    chk("out_data",  out_data, (mq.size() > 0) ? mq[0] : m_last);
`ifdef SEG_SKID_STATS_EN
    chk("stall_cnt", {48'd0, stall_cnt}, {48'd0, m_stall});
`endif
  endtask

  // One clock: model follows the DUT edge, outputs compared on the falling edge.
  task automatic cycle(input bit do_check);
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (do_check) check_all();
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    drive(1'b0, '0, 1'b0);
    cycle(1'b1);
    cycle(1'b1);
    reset = 1'b0;
    // Reset state
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_out_data",  out_data,           64'd0);
    chk("rst_occupancy", {62'd0, occupancy}, 64'd0);

    // First payload: visible one cycle after acceptance
    drive(1'b1, 64'hA5, 1'b0);
    cycle(1'b1);
    chk("first_valid", {63'd0, out_valid}, 64'd1);
    chk("first_data",  out_data,           64'hA5);
    drive(1'b0, '0, 1'b1);
    cycle(1'b1);

    // Streaming with out_ready held high
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 64'(i), 1'b1);
      cycle(1'b1);
      chk("stream_data", out_data, 64'(i));
      chk("stream_ready", {63'd0, in_ready}, 64'd1);
      chk("stream_occ", {62'd0, occupancy}, 64'd1);
    end
    drive(1'b0, '0, 1'b1);
    cycle(1'b1);

    // Backpressure: two accepted, third held upstream
    drive(1'b1, 64'h11, 1'b0); cycle(1'b1);
    drive(1'b1, 64'h22, 1'b0); cycle(1'b1);
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_occ", {62'd0, occupancy}, 64'd2);
    drive(1'b1, 64'h33, 1'b0); cycle(1'b1);
    chk("bp_hold_data", out_data, 64'h11);
    chk("bp_hold_occ", {62'd0, occupancy}, 64'd2);
    drive(1'b1, 64'h33, 1'b1); cycle(1'b1);
    chk("bp_out2", out_data, 64'h22);
    cycle(1'b1);
    chk("bp_out3", out_data, 64'h33);
    drive(1'b0, '0, 1'b1); cycle(1'b1);
    chk("bp_drained", {63'd0, out_valid}, 64'd0);

    // Flush from FULL while in_valid is high
    drive(1'b1, 64'h44, 1'b0); cycle(1'b1);
    drive(1'b1, 64'h55, 1'b0); cycle(1'b1);
    flush = 1'b1; drive(1'b1, 64'h66, 1'b0); cycle(1'b1);
    flush = 1'b0;
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_occ", {62'd0, occupancy}, 64'd0);
    chk("flush_ready", {63'd0, in_ready}, 64'd1);
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1);
      chk("flush_quiet", {63'd0, out_valid}, 64'd0);
    end

    // Reset beats flush and transfers in FULL
    drive(1'b1, 64'h77, 1'b0); cycle(1'b1);
    drive(1'b1, 64'h88, 1'b0); cycle(1'b1);
    reset = 1'b1; flush = 1'b1; drive(1'b1, 64'h99, 1'b1); cycle(1'b1);
    reset = 1'b0; flush = 1'b0;
    chk("rstp_occ", {62'd0, occupancy}, 64'd0);
    chk("rstp_data", out_data, 64'd0);
    chk("rstp_valid", {63'd0, out_valid}, 64'd0);

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 2) != 0));
      flush = ($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 99) == 0);
      cycle(1'b1);
    end
    reset = 1'b0; flush = 1'b0;
    drive(1'b0, '0, 1'b1);
    cycle(1'b1);

`ifdef SEG_SKID_STATS_EN
    // Long stall saturates the counter; flush must not clear it
    drive(1'b1, 64'hBEEF, 1'b0); cycle(1'b1);
    drive(1'b0, '0, 1'b0);
    for (int i = 0; i < 70000; i++) cycle(1'b0);
    check_all();
    chk("stall_sat", {48'd0, stall_cnt}, 64'hFFFF);
    flush = 1'b1; cycle(1'b1);
    flush = 1'b0;
    chk("stall_after_flush", {48'd0, stall_cnt}, 64'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
